// File: rtl/io_responder_if.sv
// io_responder bus bundle: CPU ioack handshake,
// host RX/TX word streams and status outputs.
interface io_responder_if #(
  parameter int DEPTH_LOG2 = 3
);
  logic                  io_read;
  logic                  io_write;
  logic                  selframe;
  logic [15:0]           io_wdata;
  logic                  ioack;
  logic [15:0]           io_rdata;
  logic                  in_valid;
  logic [15:0]           in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [15:0]           out_data;
  logic                  out_ready;
  logic [15:0]           frame;
  logic [DEPTH_LOG2:0]   rx_count;

  modport slave (
    input  io_read,
    input  io_write,
    input  selframe,
    input  io_wdata,
    output ioack,
    output io_rdata,
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready,
    output frame,
    output rx_count
  );

  modport master (
    output io_read,
    output io_write,
    output selframe,
    output io_wdata,
    input  ioack,
    input  io_rdata,
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready,
    input  frame,
    input  rx_count
  );
endinterface

// File: rtl/io_responder.sv
// Device end of the CPU I/O syscall handshake.
// Ports: clock, reset (sync, active high), bus
//   (slave: io_read/io_write/selframe/io_wdata
//   in, ioack/io_rdata out; RX stream in_valid/
//   in_data/in_ready; TX stream out_valid/
//   out_data/out_ready; frame, rx_count status).
module io_responder #(
  parameter int DEPTH_LOG2 = 3
) (
  input logic           clock,
  input logic           reset,
  io_responder_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  localparam logic [DEPTH_LOG2-1:0] PINC =
    DEPTH_LOG2'(1);

  typedef enum logic {
    IDLE,
    ACK
  } state_t;

  state_t state;
  state_t state_n;

  logic [15:0] rdata_q;
  logic [15:0] frame_q;

  logic [15:0]           rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wp;
  logic [DEPTH_LOG2-1:0] rx_rp;
  logic [CW-1:0]         rx_cnt;

  logic [15:0]           tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wp;
  logic [DEPTH_LOG2-1:0] tx_rp;
  logic [CW-1:0]         tx_cnt;

  logic rx_empty;
  logic rx_full;
  logic tx_empty;
  logic tx_full;

  logic rd;
  logic wr;
  logic req;

  logic rx_push;
  logic rx_pop;
  logic tx_push;
  logic tx_pop;
  logic tx_room;
  logic frame_we;
  logic rd_frame;

  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL);
  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == FULL);

  // Read wins when both requests are raised.
  assign rd  = bus.io_read;
  assign wr  = bus.io_write & ~bus.io_read;
  assign req = bus.io_read | bus.io_write;

  assign tx_pop  = ~tx_empty & bus.out_ready;

  // A full TX can still take a store in the
  // same cycle the host drains its head.
  assign tx_room = ~tx_full | tx_pop;

  always_comb begin
    state_n  = state;
    rx_pop   = 1'b0;
    tx_push  = 1'b0;
    frame_we = 1'b0;
    rd_frame = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          rd & bus.selframe: begin
            rd_frame = 1'b1;
            state_n  = ACK;
          end
          rd & ~bus.selframe & ~rx_empty: begin
            rx_pop  = 1'b1;
            state_n = ACK;
          end
          wr & bus.selframe: begin
            frame_we = 1'b1;
            state_n  = ACK;
          end
          wr & ~bus.selframe & tx_room: begin
            tx_push = 1'b1;
            state_n = ACK;
          end
          default: begin
            state_n = IDLE;
          end
        endcase
      end
      ACK: begin
        if (!req) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // A full RX still accepts a host word when a
  // LOAD pops in the same cycle.
  assign bus.in_ready = ~rx_full | rx_pop;
  assign rx_push      = bus.in_valid & bus.in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      rdata_q <= '0;
      frame_q <= '0;
    end else begin
      state <= state_n;
      if (rd_frame) begin
        rdata_q <= frame_q;
      end
      if (rx_pop) begin
        rdata_q <= rx_mem[rx_rp];
      end
      if (frame_we) begin
        frame_q <= bus.io_wdata;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rx_push) begin
      rx_mem[rx_wp] <= bus.in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) begin
        rx_wp <= rx_wp + PINC;
      end
      if (rx_pop) begin
        rx_rp <= rx_rp + PINC;
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + ONE;
        2'b01:   rx_cnt <= rx_cnt - ONE;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (tx_push) begin
      tx_mem[tx_wp] <= bus.io_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) begin
        tx_wp <= tx_wp + PINC;
      end
      if (tx_pop) begin
        tx_rp <= tx_rp + PINC;
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + ONE;
        2'b01:   tx_cnt <= tx_cnt - ONE;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  assign bus.ioack     = (state == ACK);
  assign bus.io_rdata  = rdata_q;
  assign bus.frame     = frame_q;
  assign bus.rx_count  = rx_cnt;
  assign bus.out_valid = ~tx_empty;
  assign bus.out_data  = tx_mem[tx_rp];

endmodule

// File: doc/io_responder.md
Name: io_responder

Overview:
Device-side end of the CPU I/O syscall handshake. It answers io_read / io_write requests (qualified by selframe) with a four-phase ioack handshake.
- Plain LOAD/STORE requests pop an RX FIFO or push a TX FIFO; these FIFOs connect to external valid/ready word streams.
- FRAME_GET/FRAME_PUT requests read or write a 16-bit frame register.
- Sits between the CPU's I/O controller and the host/peripheral streams.

Parameters:
DEPTH_LOG2, 3, log2 of entries in each of the RX and TX FIFOs (depth 8)

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
io_read  in  1  CPU read request (LOAD or FRAME_GET), held until ioack seen
io_write  in  1  CPU write request (STORE or FRAME_PUT), held until ioack seen
selframe  in  1  1 = frame register access, 0 = FIFO stream access
io_wdata  in  16  CPU accumulator value for writes
ioack  out  1  handshake acknowledge (registered)
io_rdata  out  16  read data, valid whenever ioack=1 after a read
in_valid  in  1  host word available
in_data  in  16  host word
in_ready  out  1  RX FIFO not full
out_valid  out  1  TX FIFO not empty
out_data  out  16  TX FIFO head word
out_ready  in  1  host consumes out_data when out_valid & out_ready
frame  out  16  current frame register value
rx_count  out  DEPTH_LOG2+1  RX FIFO occupancy

Behaviour:
Reset (synchronous, takes effect at the next posedge, overrides everything):
- ioack=0, io_rdata=0, frame=0.
- Both FIFOs emptied, so rx_count=0, in_ready=1, out_valid=0.
- FSM goes to IDLE.
- A reset mid-handshake drops ioack, and the pending request is simply re-evaluated from IDLE afterwards.

FSM states:
- IDLE, ioack=0. Evaluate the request every cycle; read has priority if io_read and io_write are both high.
  - io_read & selframe: io_rdata<=frame, go ACK.
  - io_read & ~selframe & RX not empty: io_rdata<=RX head, pop RX, go ACK.
  - io_read & ~selframe & RX empty: stay IDLE (stall). Retry every cycle; a word arriving on in_valid becomes readable the cycle after it is written.
  - io_write & selframe: frame<=io_wdata, go ACK.
  - io_write & ~selframe & TX not full: push io_wdata into TX, go ACK.
  - io_write & ~selframe & TX full: stall in IDLE.
- ACK, ioack=1.
  - io_rdata stays stable throughout ACK.
  - Remain in ACK while io_read|io_write is high.
  - When both are low, ioack<=0 and go IDLE. ioack is low one cycle after the request drops.
- A request is serviced exactly once per handshake. No second pop or push happens while in ACK, even if the request stays high.

Timing:
- Request to ioack: 1 cycle when serviceable.
- The CPU samples io_rdata on the first ioack=1 cycle.

RX FIFO:
- Push when in_valid & in_ready.
- A pop and a push in the same cycle are allowed, including when the FIFO is full, in which case the count is unchanged.
- Pop applies only at the single IDLE->ACK transition.
- rx_count updates each cycle by +push -pop.

TX FIFO:
- Pop when out_valid & out_ready.
- out_data is the head word, combinational from storage.
- A push in the same cycle as a pop is allowed; a push when full is permitted only if a pop occurs in that cycle.

General:
- Read and write pointers are DEPTH_LOG2 bits and wrap modulo depth.
- Full and empty are derived from the occupancy counter.

Test Plan:
- Reset, then FRAME_PUT: io_write=1, selframe=1, io_wdata=16'h1234 → ioack=1 on the next cycle and frame=16'h1234. Drop io_write → ioack=0 one cycle later. Then FRAME_GET → io_rdata=16'h1234 while ioack=1.
- Push 3 words A1,A2,A3 via in_valid, then three LOAD handshakes → io_rdata=A1, A2, A3 in order, rx_count 3→0. A fourth LOAD with RX empty stalls with ioack=0. Send A4 → ack within 2 cycles with io_rdata=A4.
- With out_ready=0, perform 8 STOREs 0..7 → all acked and out_valid=1. The 9th STORE stalls. Raise out_ready for one cycle → word 0 emitted, then the 9th STORE is acked. out_data then sequences 1..8.
- Hold io_read high for 5 cycles after ack with 2 words in RX → exactly one pop (rx_count 2→1) and ioack stays 1 until io_read drops.
- Fill RX to 8 (in_ready=0), then in one cycle LOAD-pop while in_valid=1 → rx_count stays 8 and there is no overflow or lost word. Wrap-around check: 20 push/pop cycles return data in FIFO order.
- Assert reset while in ACK with 2 TX words pending → next cycle ioack=0, out_valid=0, frame=0, rx_count=0.
